// File: rtl/data_sram_responder.sv
// Responder end of the CPU data-SRAM interface: a word array answering single-word
// requests after LATENCY cycles, optionally stretched by 0..3 LFSR-drawn wait cycles.
module data_sram_responder #(
   parameter int unsigned DEPTH_LOG2 = 12,
   parameter int unsigned LATENCY    = 2,
   parameter bit          JITTER_EN  = 1'b0,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        data_sram_data_ok,
   output logic        busy
);

   localparam int unsigned WORDS = 1 << DEPTH_LOG2;
   localparam int unsigned CNT_W = 5;
   localparam logic [CNT_W-1:0] BASE_CNT = CNT_W'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state;
   state_t next_state;

   logic [31:0]           mem [WORDS];
   logic [DEPTH_LOG2-1:0] in_idx;
   logic [DEPTH_LOG2-1:0] req_idx;
   logic [DEPTH_LOG2-1:0] rd_idx_c;
   logic [3:0]            req_wen;
   logic [31:0]           req_wdata;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      load_cnt;
   logic [15:0]           lfsr;
   logic                  lfsr_fb;
   logic [1:0]            extra;
   logic                  accept_c;
   logic                  ok_next_c;
   logic                  busy_next_c;
   logic                  unused_addr;

   // Word index drops the byte offset; upper bits alias modulo the array size.
   assign in_idx      = data_sram_addr[DEPTH_LOG2+1:2];
   assign unused_addr = ^data_sram_addr;

   assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
   assign extra    = JITTER_EN ? lfsr[1:0] : 2'b00;
   assign load_cnt = BASE_CNT + CNT_W'(extra);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; WAIT leaves on the cycle its counter drains to zero.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (data_sram_en) begin
               next_state = (load_cnt == '0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (cnt == CNT_W'(1)) begin
               next_state = RESP;
            end
         end
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output decode; the read index bypasses the request latch when IDLE goes straight to RESP.
   always_comb begin
      accept_c    = 1'b0;
      ok_next_c   = 1'b0;
      busy_next_c = 1'b0;
      rd_idx_c    = req_idx;
      accept_c    = (state == IDLE) && data_sram_en;
      ok_next_c   = (next_state == RESP);
      busy_next_c = (next_state != IDLE);
      if (state == IDLE) begin
         rd_idx_c = in_idx;
      end
   end

   // Registered outputs; rdata captures the pre-write word on entry to RESP and then holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_sram_data_ok <= 1'b0;
         busy              <= 1'b0;
         data_sram_rdata   <= '0;
      end else begin
         data_sram_data_ok <= ok_next_c;
         busy              <= busy_next_c;
         if (ok_next_c) begin
            data_sram_rdata <= mem[rd_idx_c];
         end
      end
   end

   // Request latch, wait counter and jitter LFSR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_idx   <= '0;
         req_wen   <= '0;
         req_wdata <= '0;
         cnt       <= '0;
         lfsr      <= LFSR_SEED;
      end else if (accept_c) begin
         req_idx   <= in_idx;
         req_wen   <= data_sram_wen;
         req_wdata <= data_sram_wdata;
         cnt       <= load_cnt;
         lfsr      <= {lfsr[14:0], lfsr_fb};
      end else if (state == WAIT) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   // Byte-enabled write commits at the edge that ends RESP; a reset leaves RESP first.
   always_ff @(posedge clk) begin
      if (state == RESP) begin
         for (int b = 0; b < 4; b++) begin
            if (req_wen[b]) begin
               mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_sram_responder.sv
// Bench for data_sram_responder: three instances (slow, fast/aliasing, jittered) checked
// each cycle against a transaction-level model plus literal directed expectations.
module tb_data_sram_responder;

   logic        clk = 1'b0;
   logic        rst   [3];
   logic        en    [3];
   logic [3:0]  wen   [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [31:0] rdata [3];
   logic        ok    [3];
   logic        busy  [3];

   int n_checks = 0;
   int n_fail   = 0;
   int issued [3];
   int n_resp [3];

   always #5 clk = ~clk;

   data_sram_responder #(.DEPTH_LOG2(12), .LATENCY(3), .JITTER_EN(1'b0), .LFSR_SEED(16'hACE1)) u_d0 (
      .clk(clk), .rst(rst[0]), .data_sram_en(en[0]), .data_sram_wen(wen[0]),
      .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]), .data_sram_rdata(rdata[0]),
      .data_sram_data_ok(ok[0]), .busy(busy[0]));

   data_sram_responder #(.DEPTH_LOG2(4), .LATENCY(1), .JITTER_EN(1'b0), .LFSR_SEED(16'hACE1)) u_d1 (
      .clk(clk), .rst(rst[1]), .data_sram_en(en[1]), .data_sram_wen(wen[1]),
      .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]), .data_sram_rdata(rdata[1]),
      .data_sram_data_ok(ok[1]), .busy(busy[1]));

   data_sram_responder #(.DEPTH_LOG2(6), .LATENCY(2), .JITTER_EN(1'b1), .LFSR_SEED(16'hACE1)) u_d2 (
      .clk(clk), .rst(rst[2]), .data_sram_en(en[2]), .data_sram_wen(wen[2]),
      .data_sram_addr(addr[2]), .data_sram_wdata(wdata[2]), .data_sram_rdata(rdata[2]),
      .data_sram_data_ok(ok[2]), .busy(busy[2]));

   function automatic int lat_of(input int d);
      return (d == 0) ? 3 : (d == 1) ? 1 : 2;
   endfunction

   function automatic int dep_of(input int d);
      return (d == 0) ? 12 : (d == 1) ? 4 : 6;
   endfunction

   function automatic bit jit_of(input int d);
      return d == 2;
   endfunction

   function automatic logic [31:0] init_word(input int d, input int i);
      return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0101) ^ (32'(d) << 28);
   endfunction

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void chk_rng(input string nm, input int v, input int lo, input int hi);
      n_checks++;
      if (v < lo || v > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected within [%0d,%0d] at %0t", nm, v, lo, hi, $time);
      end
   endfunction

   // Transaction-level reference: memory image, pending request, response edge.
   logic [31:0] rm [3][4096];
   bit          act_m  [3];
   int          acc_e  [3];
   int          resp_e [3];
   logic [15:0] lfsr_m [3];
   logic [3:0]  q_wen  [3];
   logic [31:0] q_addr [3];
   logic [31:0] q_wd   [3];
   logic [31:0] x_rd   [3];

   initial begin : compare
      int          cyc;
      logic        s_rst [3];
      logic        s_en  [3];
      logic [3:0]  s_wen [3];
      logic [31:0] s_adr [3];
      logic [31:0] s_wd  [3];
      cyc = 0;
      for (int d = 0; d < 3; d++) begin
         act_m[d] = 1'b0; lfsr_m[d] = 16'hACE1; x_rd[d] = '0; n_resp[d] = 0;
      end
      forever begin
         @(posedge clk);
         cyc++;
         for (int d = 0; d < 3; d++) begin
            s_rst[d] = rst[d]; s_en[d] = en[d]; s_wen[d] = wen[d];
            s_adr[d] = addr[d]; s_wd[d] = wdata[d];
         end
         #1;
         for (int d = 0; d < 3; d++) begin
            bit x_ok;
            if (s_rst[d]) begin
               act_m[d] = 1'b0; x_rd[d] = '0; lfsr_m[d] = 16'hACE1;
            end else if (act_m[d] && cyc == resp_e[d] + 1) begin
               act_m[d] = 1'b0;
            end else if (!act_m[d] && s_en[d]) begin
               int ex;
               ex = jit_of(d) ? int'(lfsr_m[d][1:0]) : 0;
               lfsr_m[d] = {lfsr_m[d][14:0],
                            lfsr_m[d][15] ^ lfsr_m[d][13] ^ lfsr_m[d][12] ^ lfsr_m[d][10]};
               act_m[d] = 1'b1; acc_e[d] = cyc; resp_e[d] = cyc + lat_of(d) - 1 + ex;
               q_wen[d] = s_wen[d]; q_addr[d] = s_adr[d]; q_wd[d] = s_wd[d];
            end
            x_ok = act_m[d] && (cyc == resp_e[d]);
            if (x_ok) begin
               int idx;
               idx = int'((q_addr[d] >> 2) & ((32'd1 << dep_of(d)) - 32'd1));
               x_rd[d] = rm[d][idx];
               for (int b = 0; b < 4; b++)
                  if (q_wen[d][b]) rm[d][idx][8*b +: 8] = q_wd[d][8*b +: 8];
               n_resp[d]++;
               chk_rng($sformatf("d%0d_latency", d), resp_e[d] - acc_e[d] + 1,
                       lat_of(d), lat_of(d) + (jit_of(d) ? 3 : 0));
            end
            chk($sformatf("d%0d_data_ok", d), 32'(ok[d]), 32'(x_ok));
            chk($sformatf("d%0d_busy", d), 32'(busy[d]), 32'(act_m[d]));
            chk($sformatf("d%0d_rdata", d), rdata[d], x_rd[d]);
         end
      end
   end

   // Present a request at the current negedge and wait for its data_ok (en left high).
   task automatic do_req(input int d, input logic [3:0] w, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] got, output int lat);
      en[d] = 1'b1; wen[d] = w; addr[d] = a; wdata[d] = wd;
      issued[d]++;
      got = '0;
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         lat++;
         if (ok[d]) begin
            got = rdata[d];
            return;
         end
      end
      chk($sformatf("d%0d_req_timeout", d), 32'(lat), 32'd0);
   endtask

   task automatic idle(input int d);
      en[d] = 1'b0; wen[d] = 4'h0; addr[d] = 32'hFFFF_FFFC; wdata[d] = 32'h5A5A_5A5A;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got no finish expected finish by 500000");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      logic [31:0] got;
      int          lat;
      int          gap;
      logic [3:0]  w;
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1; issued[d] = 0; idle(d);
      end
      for (int i = 0; i < 4096; i++) begin
         u_d0.mem[i] = init_word(0, i); rm[0][i] = init_word(0, i);
         rm[1][i] = init_word(1, i); rm[2][i] = init_word(2, i);
      end
      u_d0.mem[4] = 32'h1122_3344; rm[0][4] = 32'h1122_3344;
      for (int i = 0; i < 16; i++) u_d1.mem[i] = init_word(1, i);
      for (int i = 0; i < 64; i++) u_d2.mem[i] = init_word(2, i);

      repeat (2) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("d%0d_rst_ok", d), 32'(ok[d]), 32'd0);
         chk($sformatf("d%0d_rst_busy", d), 32'(busy[d]), 32'd0);
         chk($sformatf("d%0d_rst_rdata", d), rdata[d], 32'd0);
         rst[d] = 1'b0;
      end
      @(negedge clk);

      // Read latency, then byte-enabled write and read-back.
      do_req(0, 4'b0000, 32'h10, 32'h0, got, lat);
      chk("rd_data", got, 32'h1122_3344);
      chk("rd_lat", 32'(lat), 32'd3);
      idle(0);
      @(negedge clk);
      chk("rd_pulse_width", 32'(ok[0]), 32'd0);
      do_req(0, 4'b0101, 32'h10, 32'hAABB_CCDD, got, lat);
      chk("bw_old_word", got, 32'h1122_3344);
      idle(0);
      @(negedge clk);
      do_req(0, 4'b0000, 32'h10, 32'h0, got, lat);
      chk("bw_merged", got, 32'h11BB_33DD);
      idle(0);
      @(negedge clk);

      // Reset while a write to word 2 sits in WAIT.
      en[0] = 1'b1; wen[0] = 4'hF; addr[0] = 32'h8; wdata[0] = 32'hFFFF_0000;
      @(negedge clk);
      chk("mid_busy_before", 32'(busy[0]), 32'd1);
      rst[0] = 1'b1;
      idle(0);
      @(negedge clk);
      chk("mid_rst_ok", 32'(ok[0]), 32'd0);
      chk("mid_rst_busy", 32'(busy[0]), 32'd0);
      @(negedge clk);
      rst[0] = 1'b0;
      @(negedge clk);
      chk("mid_mem2_direct", u_d0.mem[2], init_word(0, 2));
      do_req(0, 4'b0000, 32'h8, 32'h0, got, lat);
      chk("mid_mem2_read", got, init_word(0, 2));
      chk("mid_next_lat", 32'(lat), 32'd3);
      idle(0);
      @(negedge clk);

      // Back-to-back reads with en held high, LATENCY=1.
      do_req(1, 4'b0000, 32'h14, 32'h0, got, lat);
      chk("b2b_w5", got, init_word(1, 5));
      chk("b2b_lat0", 32'(lat), 32'd1);
      do_req(1, 4'b0000, 32'h18, 32'h0, got, lat);
      chk("b2b_w6", got, init_word(1, 6));
      chk("b2b_lat1", 32'(lat), 32'd2);
      do_req(1, 4'b0000, 32'h1C, 32'h0, got, lat);
      chk("b2b_w7", got, init_word(1, 7));
      chk("b2b_lat2", 32'(lat), 32'd2);
      idle(1);
      @(negedge clk);

      // Aliasing and unaligned address on a 16-word array.
      do_req(1, 4'hF, 32'h0000_0043, 32'hDEAD_BEEF, got, lat);
      idle(1);
      @(negedge clk);
      do_req(1, 4'b0000, 32'h40, 32'h0, got, lat);
      chk("alias_40", got, 32'hDEAD_BEEF);
      idle(1);
      @(negedge clk);
      do_req(1, 4'b0000, 32'h0, 32'h0, got, lat);
      chk("alias_00", got, 32'hDEAD_BEEF);
      idle(1);
      @(negedge clk);

      // Jittered random traffic.
      for (int n = 0; n < 200; n++) begin
         w = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'b0000;
         do_req(2, w, $urandom, $urandom, got, lat);
         if (n == 0) chk("jit_first_lat", 32'(lat), 32'd3);
         gap = $urandom_range(0, 2);
         if (gap > 0) begin
            idle(2);
            repeat (gap) @(negedge clk);
         end
      end
      idle(2);
      repeat (6) @(negedge clk);

      for (int d = 0; d < 3; d++)
         chk($sformatf("d%0d_resp_count", d), 32'(n_resp[d]), 32'(issued[d]));
      chk("d2_total", 32'(n_resp[2]), 32'd200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
